// File: rtl/baw_pkg.sv
// Shared encodings and default sizes for the black-and-white game controller.
package baw_pkg;

  // Default game dimensions
  localparam int NUM_CARDS_DEF  = 9;
  localparam int MAX_ROUNDS_DEF = 9;
  localparam int IDX_W_DEF      = 4;

  // Round sequencer states; values are exported on state_o for display selection
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_ROUND_SHOW  = 3'd1,
    ST_LEAD_SEL    = 3'd2,
    ST_FOLLOW_SEL  = 3'd3,
    ST_RESOLVE     = 3'd4,
    ST_RESULT_SHOW = 3'd5,
    ST_GAME_OVER   = 3'd6
  } state_t;

  // Comparator result encodings (2'b11 is treated as a draw)
  localparam logic [1:0] MR_DRAW   = 2'b00;
  localparam logic [1:0] MR_P1_WIN = 2'b01;
  localparam logic [1:0] MR_P2_WIN = 2'b10;
  localparam logic [1:0] MR_ALT    = 2'b11;

  // Player identifiers as used on active_player / leader
  localparam logic PLAYER_P1 = 1'b0;
  localparam logic PLAYER_P2 = 1'b1;

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer followed by a rising-edge detector for one raw button.
// The pulse is high for one cycle, two clocks after the raw level rises, so the
// FSM consuming it acts on the third clock edge.
module btn_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic pulse
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;

  // Shift the raw level through the synchronizer and remember the last synced value
  always_comb begin
    sync_d = {sync_q[0], raw};
    prev_d = sync_q[1];
  end

  // Synchronizer and history registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign pulse = sync_q[1] & ~prev_q;

endmodule

// File: rtl/baw_turn_sequencer.sv
// Round sequencer for the black-and-white card game: button edges, card masks,
// latched card indices, commit/score strobes and leader tracking.
module baw_turn_sequencer
  import baw_pkg::*;
#(
  parameter int NUM_CARDS  = NUM_CARDS_DEF,
  parameter int MAX_ROUNDS = MAX_ROUNDS_DEF,
  parameter int IDX_W      = IDX_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 btn_start,
  input  logic                 btn_confirm,
  input  logic                 btn_abort,
  input  logic [NUM_CARDS-1:0] sel,
  input  logic [1:0]           match_result,
  input  logic                 finish,
  output logic [2:0]           state_o,
  output logic                 active_player,
  output logic                 leader,
  output logic [NUM_CARDS-1:0] p1_mask,
  output logic [NUM_CARDS-1:0] p2_mask,
  output logic [IDX_W-1:0]     p1_idx,
  output logic [IDX_W-1:0]     p2_idx,
  output logic                 p1_commit,
  output logic                 p2_commit,
  output logic                 score_pulse,
  output logic                 score_clear,
  output logic                 sel_error,
  output logic [IDX_W-1:0]     round_idx
);

  localparam logic [IDX_W-1:0] ROUND_LAST = IDX_W'(MAX_ROUNDS);

  logic start_e, confirm_e, abort_e;

  btn_edge u_start   (.clk(clk), .reset_n(reset_n), .raw(btn_start),   .pulse(start_e));
  btn_edge u_confirm (.clk(clk), .reset_n(reset_n), .raw(btn_confirm), .pulse(confirm_e));
  btn_edge u_abort   (.clk(clk), .reset_n(reset_n), .raw(btn_abort),   .pulse(abort_e));

  state_t               state_q, state_d;
  logic                 active_q, active_d;
  logic                 leader_q, leader_d;
  logic [NUM_CARDS-1:0] p1_mask_q, p1_mask_d;
  logic [NUM_CARDS-1:0] p2_mask_q, p2_mask_d;
  logic [IDX_W-1:0]     p1_idx_q, p1_idx_d;
  logic [IDX_W-1:0]     p2_idx_q, p2_idx_d;
  logic [IDX_W-1:0]     round_q, round_d;
  logic                 sel_error_q, sel_error_d;

  logic [NUM_CARDS-1:0] act_mask;
  logic                 sel_onehot;
  logic                 sel_valid;
  logic [IDX_W-1:0]     sel_enc;
  logic                 reinit;

  // Selection qualification: exactly one bit set, and that card still in the active hand
  always_comb begin
    act_mask   = (active_q == PLAYER_P2) ? p2_mask_q : p1_mask_q;
    sel_onehot = (sel != '0) && ((sel & (sel - NUM_CARDS'(1))) == '0);
    sel_valid  = sel_onehot && ((sel & act_mask) != '0);
    sel_enc    = '0;
    for (int i = 0; i < NUM_CARDS; i++) begin
      if (sel[i]) sel_enc = IDX_W'(i);
    end
  end

  // Next-state, register updates and single-cycle strobes
  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    leader_d    = leader_q;
    p1_mask_d   = p1_mask_q;
    p2_mask_d   = p2_mask_q;
    p1_idx_d    = p1_idx_q;
    p2_idx_d    = p2_idx_q;
    round_d     = round_q;
    sel_error_d = sel_error_q;
    p1_commit   = 1'b0;
    p2_commit   = 1'b0;
    score_pulse = 1'b0;
    score_clear = 1'b0;
    reinit      = 1'b0;

    if (abort_e && (state_q != ST_IDLE)) begin
      // Abort wins over everything else that cycle, including a pending commit or score
      state_d     = ST_IDLE;
      score_clear = 1'b1;
      reinit      = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_e) begin
            state_d     = ST_ROUND_SHOW;
            score_clear = 1'b1;
            reinit      = 1'b1;
          end
        end
        ST_ROUND_SHOW: begin
          if (confirm_e) begin
            state_d  = ST_LEAD_SEL;
            active_d = leader_q;
          end
        end
        ST_LEAD_SEL, ST_FOLLOW_SEL: begin
          if (confirm_e) begin
            if (sel_valid) begin
              sel_error_d = 1'b0;
              if (active_q == PLAYER_P2) begin
                p2_commit = 1'b1;
                p2_idx_d  = sel_enc;
                p2_mask_d = p2_mask_q & ~sel;
              end else begin
                p1_commit = 1'b1;
                p1_idx_d  = sel_enc;
                p1_mask_d = p1_mask_q & ~sel;
              end
              if (state_q == ST_LEAD_SEL) begin
                state_d  = ST_FOLLOW_SEL;
                active_d = ~active_q;
              end else begin
                state_d = ST_RESOLVE;
              end
            end else begin
              sel_error_d = 1'b1;
            end
          end
        end
        ST_RESOLVE: begin
          score_pulse = 1'b1;
          round_d     = (round_q >= ROUND_LAST) ? ROUND_LAST : round_q + IDX_W'(1);
          if (match_result == MR_P1_WIN)      leader_d = PLAYER_P1;
          else if (match_result == MR_P2_WIN) leader_d = PLAYER_P2;
          state_d = ST_RESULT_SHOW;
        end
        ST_RESULT_SHOW: begin
          if (confirm_e) begin
            state_d = (finish || (round_q == ROUND_LAST)) ? ST_GAME_OVER : ST_ROUND_SHOW;
          end
        end
        ST_GAME_OVER: begin
          if (start_e) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A selection error is only meaningful while the state it was raised in persists
    if (state_d != state_q) sel_error_d = 1'b0;

    // Fresh game (start from IDLE) or abort: same values as after reset
    if (reinit) begin
      active_d    = PLAYER_P1;
      leader_d    = PLAYER_P1;
      p1_mask_d   = '1;
      p2_mask_d   = '1;
      p1_idx_d    = '0;
      p2_idx_d    = '0;
      round_d     = '0;
      sel_error_d = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      active_q    <= PLAYER_P1;
      leader_q    <= PLAYER_P1;
      p1_mask_q   <= '1;
      p2_mask_q   <= '1;
      p1_idx_q    <= '0;
      p2_idx_q    <= '0;
      round_q     <= '0;
      sel_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      leader_q    <= leader_d;
      p1_mask_q   <= p1_mask_d;
      p2_mask_q   <= p2_mask_d;
      p1_idx_q    <= p1_idx_d;
      p2_idx_q    <= p2_idx_d;
      round_q     <= round_d;
      sel_error_q <= sel_error_d;
    end
  end

  assign state_o       = state_q;
  assign active_player = active_q;
  assign leader        = leader_q;
  assign p1_mask       = p1_mask_q;
  assign p2_mask       = p2_mask_q;
  assign p1_idx        = p1_idx_q;
  assign p2_idx        = p2_idx_q;
  assign sel_error     = sel_error_q;
  assign round_idx     = round_q;

endmodule

// File: tb/tb_baw_turn_sequencer.sv
// Scoreboard bench for baw_turn_sequencer: stimulus pushes the expected strobe
// sequence, a monitor pops and checks whenever a strobe appears.
module tb_baw_turn_sequencer;

  localparam int K_P1C   = 0;
  localparam int K_P2C   = 1;
  localparam int K_SCORE = 2;
  localparam int K_CLEAR = 3;

  typedef struct {
    int         kind;
    logic [3:0] idx;
    logic [8:0] mask;
    logic       ldr;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_start = 1'b0, btn_confirm = 1'b0, btn_abort = 1'b0;
  logic [8:0] sel = '0;
  logic [1:0] match_result = 2'b00;
  logic       finish = 1'b0;
  logic [2:0] state_o;
  logic       active_player, leader;
  logic [8:0] p1_mask, p2_mask;
  logic [3:0] p1_idx, p2_idx, round_idx;
  logic       p1_commit, p2_commit, score_pulse, score_clear, sel_error;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // bench model of game progress
  logic [8:0] m1, m2;
  logic       ldr;
  int         rnd;

  baw_turn_sequencer dut (
    .clk(clk), .reset_n(reset_n), .btn_start(btn_start), .btn_confirm(btn_confirm),
    .btn_abort(btn_abort), .sel(sel), .match_result(match_result), .finish(finish),
    .state_o(state_o), .active_player(active_player), .leader(leader),
    .p1_mask(p1_mask), .p2_mask(p2_mask), .p1_idx(p1_idx), .p2_idx(p2_idx),
    .p1_commit(p1_commit), .p2_commit(p2_commit), .score_pulse(score_pulse),
    .score_clear(score_clear), .sel_error(sel_error), .round_idx(round_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic push(input int kind, input logic [3:0] idx, input logic [8:0] mask, input logic l);
    exp_t e;
    e.kind = kind; e.idx = idx; e.mask = mask; e.ldr = l;
    exp_q.push_back(e);
  endtask

  // Raise the given buttons for a few cycles (edge acts on the 3rd clock), then release
  task automatic press(input logic s, input logic c, input logic a);
    @(negedge clk);
    btn_start = s; btn_confirm = c; btn_abort = a;
    repeat (4) @(posedge clk);
    @(negedge clk);
    btn_start = 1'b0; btn_confirm = 1'b0; btn_abort = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic new_game();
    push(K_CLEAR, 4'd0, 9'h1FF, 1'b0);
    m1 = 9'h1FF; m2 = 9'h1FF; ldr = 1'b0; rnd = 0;
    press(1, 0, 0);
    chk("start_to_round_show", state_o, 3'd1);
  endtask

  // One full valid round where both players spend card r
  task automatic play_round(input int r, input logic [1:0] mr, input logic fin, input logic over);
    logic [8:0] card;
    card = 9'd1 << r;
    press(0, 1, 0);
    chk("lead_sel_state", state_o, 3'd2);
    chk("lead_active_is_leader", active_player, ldr);
    sel = card;
    if (ldr) begin m2 = m2 & ~card; push(K_P2C, 4'(r), m2, 1'b0); end
    else     begin m1 = m1 & ~card; push(K_P1C, 4'(r), m1, 1'b0); end
    press(0, 1, 0);
    chk("follow_sel_state", state_o, 3'd3);
    if (!ldr) begin m2 = m2 & ~card; push(K_P2C, 4'(r), m2, 1'b0); end
    else      begin m1 = m1 & ~card; push(K_P1C, 4'(r), m1, 1'b0); end
    if (mr == 2'b01) ldr = 1'b0;
    else if (mr == 2'b10) ldr = 1'b1;
    rnd = (rnd < 9) ? rnd + 1 : 9;
    push(K_SCORE, 4'(rnd), 9'h0, ldr);
    match_result = mr;
    press(0, 1, 0);
    chk("result_show_state", state_o, 3'd5);
    finish = fin;
    press(0, 1, 0);
    chk("after_result_confirm", state_o, over ? 3'd6 : 3'd1);
    finish = 1'b0;
  endtask

  // Monitor: any strobe pops one expectation; fields are checked after the edge it acts on
  initial begin
    exp_t e;
    int   k;
    forever begin
      @(negedge clk);
      if (reset_n && (p1_commit || p2_commit || score_pulse || score_clear)) begin
        chk("strobe_exclusive", $countones({p1_commit, p2_commit, score_pulse, score_clear}), 1);
        k = p1_commit ? K_P1C : p2_commit ? K_P2C : score_pulse ? K_SCORE : K_CLEAR;
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe_kind", k, 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_kind", k, e.kind);
          @(posedge clk); #1;
          case (e.kind)
            K_P1C: begin
              chk("p1_idx", p1_idx, e.idx);
              chk("p1_mask", p1_mask, e.mask);
            end
            K_P2C: begin
              chk("p2_idx", p2_idx, e.idx);
              chk("p2_mask", p2_mask, e.mask);
            end
            K_SCORE: begin
              chk("round_idx", round_idx, e.idx);
              chk("leader", leader, e.ldr);
            end
            default: begin
              chk("clear_masks", {p1_mask, p2_mask}, {9'h1FF, 9'h1FF});
              chk("clear_round", round_idx, 4'd0);
              chk("clear_leader", leader, 1'b0);
            end
          endcase
        end
      end
    end
  end

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_state", state_o, 3'd0);
    chk("rst_masks", {p1_mask, p2_mask}, {9'h1FF, 9'h1FF});
    chk("rst_idx_round", {p1_idx, p2_idx, round_idx}, 12'h0);
    chk("rst_flags", {leader, active_player, sel_error}, 3'b000);
    chk("rst_strobes", {p1_commit, p2_commit, score_pulse, score_clear}, 4'b0000);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // asynchronous reset while in FOLLOW_SEL with P1 mask 1FE
    new_game();
    press(0, 1, 0);
    sel = 9'h001;
    m1 = 9'h1FE;
    push(K_P1C, 4'd0, m1, 1'b0);
    press(0, 1, 0);
    chk("pre_reset_state", state_o, 3'd3);
    chk("pre_reset_p1_mask", p1_mask, 9'h1FE);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_state", state_o, 3'd0);
    chk("async_rst_masks", {p1_mask, p2_mask}, {9'h1FF, 9'h1FF});
    chk("async_rst_idx", {p1_idx, p2_idx}, 8'h00);
    chk("async_rst_leader", leader, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // game 1: directed round with invalid selections
    new_game();
    press(0, 1, 0);
    chk("g1_lead_state", state_o, 3'd2);
    sel = 9'h000;
    press(0, 1, 0);
    chk("sel_zero_error", sel_error, 1'b1);
    chk("sel_zero_hold", state_o, 3'd2);
    sel = 9'h011;
    press(0, 1, 0);
    chk("sel_multi_error", sel_error, 1'b1);
    chk("sel_multi_hold", state_o, 3'd2);
    sel = 9'h010;
    m1 = 9'h1EF;
    push(K_P1C, 4'd4, 9'h1EF, 1'b0);
    press(0, 1, 0);
    chk("valid_clears_error", sel_error, 1'b0);
    chk("follow_active_p2", active_player, 1'b1);
    sel = 9'h004;
    m2 = 9'h1FB;
    push(K_P2C, 4'd2, 9'h1FB, 1'b0);
    push(K_SCORE, 4'd1, 9'h0, 1'b1);
    match_result = 2'b10;
    press(0, 1, 0);
    chk("g1_result_state", state_o, 3'd5);
    chk("g1_idx_stable", {p1_idx, p2_idx}, {4'd4, 4'd2});
    press(0, 1, 0);
    press(0, 1, 0);
    chk("p2_leads_active", active_player, 1'b1);
    sel = 9'h004;
    press(0, 1, 0);
    chk("used_card_error", sel_error, 1'b1);
    chk("used_card_hold", state_o, 3'd2);
    sel = 9'h001;
    push(K_P2C, 4'd0, 9'h1FA, 1'b0);
    press(0, 1, 0);
    sel = 9'h002;
    push(K_P1C, 4'd1, 9'h1ED, 1'b0);
    push(K_SCORE, 4'd2, 9'h0, 1'b1);
    match_result = 2'b00;
    press(0, 1, 0);
    chk("draw_keeps_leader", leader, 1'b1);
    press(0, 1, 0);
    press(0, 1, 0);
    chk("g1_lead_again", state_o, 3'd2);
    // abort and confirm together: abort wins, no commit
    sel = 9'h100;
    push(K_CLEAR, 4'd0, 9'h1FF, 1'b0);
    press(0, 1, 1);
    chk("abort_to_idle", state_o, 3'd0);

    // game 2: nine rounds, saturates at round 9
    new_game();
    for (int r = 0; r < 9; r++) begin
      play_round(r, 2'(r % 3), 1'b0, r == 8);
    end
    chk("g2_round_idx", round_idx, 4'd9);
    press(0, 1, 0);
    chk("gameover_ignores_confirm", state_o, 3'd6);
    press(1, 0, 0);
    chk("gameover_start_idle", state_o, 3'd0);

    // game 3: held confirm produces exactly one transition
    new_game();
    sel = 9'h001;
    @(negedge clk);
    btn_confirm = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    btn_confirm = 1'b0;
    repeat (4) @(negedge clk);
    chk("held_confirm_once", state_o, 3'd2);
    push(K_CLEAR, 4'd0, 9'h1FF, 1'b0);
    press(0, 0, 1);
    chk("abort_idle_g3", state_o, 3'd0);

    // game 4: finish raised after round 5
    new_game();
    for (int r = 0; r < 5; r++) begin
      play_round(r, 2'b01, r == 4, r == 4);
    end
    chk("finish_round_idx", round_idx, 4'd5);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net against a hung run
  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/baw_turn_sequencer.md
Name: baw_turn_sequencer

Overview:
Game-flow controller for the black-and-white card game. It edge-detects the player buttons and sequences each round: leader select, follower select, resolve, result display. It owns both players' remaining-card masks and the latched hand-card indices. It drives the commit and score-update pulses consumed by the comparator and score datapath, and replaces the ad-hoc FSM in baw_main.

Parameters:
NUM_CARDS, 9, cards per player; width of masks and sel
MAX_ROUNDS, 9, rounds per game; equals NUM_CARDS
IDX_W, 4, width of card index and round counter

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
btn_start  in  1  raw button level, start game
btn_confirm  in  1  raw button level, confirm selection / advance
btn_abort  in  1  raw button level, abort to IDLE
sel  in  NUM_CARDS  switch card selection, one-hot expected
match_result  in  2  comparator result: 00 draw, 01 P1 wins, 10 P2 wins, 11 treated as draw
finish  in  1  game-over flag from score logic
state_o  out  3  current FSM state, for display selection
active_player  out  1  0=P1, 1=P2; player currently selecting
leader  out  1  player who leads the current round
p1_mask  out  NUM_CARDS  P1 remaining cards, 1=available
p2_mask  out  NUM_CARDS  P2 remaining cards
p1_idx  out  IDX_W  P1 committed card index 0..8
p2_idx  out  IDX_W  P2 committed card index
p1_commit  out  1  one-cycle pulse on a valid P1 commit
p2_commit  out  1  one-cycle pulse on a valid P2 commit
score_pulse  out  1  one-cycle score-update strobe
score_clear  out  1  one-cycle clear for the score datapath
sel_error  out  1  last confirm carried an invalid selection
round_idx  out  IDX_W  rounds completed, 0..MAX_ROUNDS

Behaviour:
- Reset (async, active-low):
  - state IDLE; masks all ones; leader=P1; active_player=P1.
  - idx=0; round_idx=0; all pulses 0; sel_error 0.
- Buttons:
  - Each button passes through a 2-flop synchronizer, then rising-edge detection.
  - An FSM action fires on an edge only; a held button fires once.
  - Edge latency from raw input is 3 cycles.
  - Simultaneous edges: priority abort > confirm > start.
- States: IDLE, ROUND_SHOW, LEAD_SEL, FOLLOW_SEL, RESOLVE, RESULT_SHOW, GAME_OVER.
- IDLE:
  - start edge -> ROUND_SHOW, with score_clear pulsed 1 cycle.
  - Masks, indices, round and leader are reinitialised to their reset values.
- ROUND_SHOW: confirm -> LEAD_SEL; active_player := leader.
- LEAD_SEL / FOLLOW_SEL, on a confirm edge:
  - The selection is valid iff sel is exactly one-hot AND (sel & active mask) != 0.
  - Valid: commit pulse for the active player (1 cycle). Its idx latches the encoded bit position. The mask bit clears on the same edge (visible next cycle). sel_error := 0.
  - Then LEAD_SEL -> FOLLOW_SEL with active_player toggled; FOLLOW_SEL -> RESOLVE.
  - Invalid (zero bits, multiple bits, or already-used card): no commit, state unchanged, sel_error := 1.
  - sel_error holds until the next confirm edge or any state change.
- RESOLVE (exactly 1 cycle):
  - score_pulse=1; round_idx increments, saturating at MAX_ROUNDS.
  - match_result is sampled this cycle; idx registers are stable from the commit.
  - leader := winner; draw or 11 leaves leader unchanged.
  - Next state is RESULT_SHOW.
- RESULT_SHOW, on confirm:
  - finish=1 or round_idx==MAX_ROUNDS -> GAME_OVER, else ROUND_SHOW.
  - finish is guaranteed settled, since a confirm edge cannot arrive earlier than 3 cycles after RESOLVE.
- GAME_OVER: start edge -> IDLE. Confirm is ignored.
- Abort edge in any non-IDLE state:
  - Next state IDLE, with the same reinitialisation as reset.
  - score_clear pulses; commits in flight are discarded; no score_pulse is emitted.
- Confirm and start edges in states where they are undefined are ignored.
- At most one of p1_commit, p2_commit, score_pulse or score_clear is high in any cycle.

Decomposition:
- Package baw_pkg holds:
  - the state encoding constants (IDLE=0 … GAME_OVER=6, 3-bit);
  - the match_result encodings;
  - NUM_CARDS and MAX_ROUNDS defaults.
- Sub-module btn_edge holds the 2-flop sync and rising-edge detector, instantiated 3×, with ports clk, reset_n, raw, pulse.
- Onehot check and index encode stay inline.

Test Plan:
- Reset mid-FOLLOW_SEL with P1 mask=9'h1FE: assert reset_n=0 -> state IDLE, masks=9'h1FF, idx=0, leader=P1 immediately (asynchronous).
- Start, then confirm in ROUND_SHOW, then sel=9'h010 and confirm -> p1_commit for 1 cycle and p1_idx=4, with p1_mask=9'h1EF next cycle. Then sel=9'h004 and confirm -> p2_commit, p2_idx=2, then RESOLVE with a single score_pulse.
- Invalid selections in LEAD_SEL, each followed by confirm -> sel_error=1, no commit, state holds:
  - sel=9'h000;
  - sel=9'h011;
  - sel=a card already used.
- match_result=10 in RESOLVE -> leader=P2; the next round's LEAD_SEL has active_player=1. match_result=00 -> leader unchanged.
- Play 9 valid rounds with finish=0 -> round_idx=9 and GAME_OVER after the 9th RESULT_SHOW confirm. finish=1 after round 5 -> GAME_OVER at that confirm.
- Abort and confirm edges in the same cycle during LEAD_SEL -> IDLE, score_clear=1, no commit. btn_confirm held for 100 cycles -> exactly one transition.
